nibble_serial_adder_ctrl: RTL and testbench
===========================================

NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk edge.
REQ-004 SHALL have port start, input, 1, request to begin an addition; accepted only in IDLE.
REQ-005 SHALL have port op_a, input, W, first operand; sampled on the start-accept edge.
REQ-006 SHALL have port op_b, input, W, second operand; sampled on the start-accept edge.
REQ-007 SHALL have port cin, input, 1, carry-in; sampled on the start-accept edge.
REQ-008 SHALL have port add_a, output, 4, nibble driven to the external 4-bit adder's a input.
REQ-009 SHALL have port add_b, output, 4, nibble driven to the adder's b input.
REQ-010 SHALL have port add_cin, output, 1, carry driven to the adder's cin input.
REQ-011 SHALL have port add_sum, input, 4, combinational sum returned by the adder.
REQ-012 SHALL have port add_cout, input, 1, combinational carry-out returned by the adder.
REQ-013 SHALL have port busy, output, 1, high while in RUN.
REQ-014 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-015 SHALL have port result, output, W, last completed sum.
REQ-016 SHALL have port cout, output, 1, carry-out of last completed sum.
REQ-017 SHALL have port ovf, output, 1, signed overflow of last completed sum (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE after nibble NIBBLES-1; DONE -> IDLE unconditionally.
REQ-019 SHALL, on start in IDLE, latch op_a, op_b, cin, clear nibble index to 0 and the accumulation register to 0.
REQ-020 SHALL, in RUN with index i, drive add_a = op_a[4i+3:4i], add_b = op_b[4i+3:4i], add_cin = carry register (latched cin when i=0).
REQ-021 SHALL, each RUN cycle, capture add_sum into accumulation nibble i and add_cout into the carry register, then increment i.
REQ-022 SHALL, on entering DONE, copy accumulation to result and the final carry to cout; done high for exactly that one cycle.
REQ-023 SHALL give latency: start accepted at edge 0 -> done high in the cycle following edge NIBBLES+1.
REQ-024 SHALL drive add_a, add_b, add_cin to 0 in IDLE and DONE.
REQ-025 SHALL ignore start in RUN and DONE; no re-latch, no queuing.
REQ-026 SHALL hold result, cout, ovf stable from done until the next DONE entry; they do not change during RUN.
REQ-027 SHALL accept start in the first IDLE cycle after DONE (back-to-back throughput NIBBLES+2 cycles).

Reset
REQ-028 SHALL, when rst is high, go to IDLE and clear busy, done, result, cout, ovf, add_a, add_b, add_cin, index, carry and accumulation to 0; rst takes priority over start.
REQ-029 SHALL abort an operation in progress on rst mid-RUN with no done pulse and no result update.

Configuration
REQ-030 SHALL, with OVERFLOW_FLAG_EN defined, set ovf in DONE to 1 when final-nibble op_a MSB equals op_b MSB and the final add_sum MSB differs from them, else 0.
REQ-031 SHALL, without OVERFLOW_FLAG_EN, keep the ovf port present and tie it to constant 0.

Verification (NIBBLES=4)
REQ-032 SHALL cover 0x1234 + 0x4321, cin=0 -> result 0x5555, cout 0, done in cycle 5 after start edge.
REQ-033 SHALL cover 0xFFFF + 0x0001, cin=0 -> result 0x0000, cout 1; add_cin observed 0,1,1,1 across RUN.
REQ-034 SHALL cover 0x000F + 0x0000, cin=1 -> result 0x0010, cout 0.
REQ-035 SHALL cover 0x7FFF + 0x0001 -> result 0x8000, ovf 1 with OVERFLOW_FLAG_EN, ovf 0 without.
REQ-036 SHALL cover start pulsed with new operands during RUN -> ignored; result equals the first operation's sum.
REQ-037 SHALL cover rst asserted in 2nd RUN cycle -> IDLE, all outputs 0, no done; next start 0x0101 + 0x0202 -> 0x0303.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: adds two W-bit operands one nibble per cycle
// through an external combinational 4-bit adder (W = 4*NIBBLES).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin an addition (honoured only in IDLE)
//   op_a, op_b, cin     operands and carry-in, latched when start is taken
//   add_a, add_b        nibble presented to the external adder
//   add_cin             carry presented to the external adder
//   add_sum, add_cout   adder response (combinational)
//   busy                high while nibbles are being processed
//   done                one-cycle pulse once result/cout/ovf are valid
//   result, cout, ovf   last completed sum, carry-out, signed overflow
//
// Optional feature: define OVERFLOW_FLAG_EN to compute ovf; otherwise
// ovf is tied to 0.
//
// Timing: start taken at edge 0, nibbles i=0..NIBBLES-1 processed at
// edges 1..NIBBLES; the last of these loads result/cout/ovf and enters
// DONE; edge NIBBLES+1 leaves DONE and raises done for one cycle, which
// is already an IDLE cycle, so a new start can be taken immediately.

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] op_a,
   input  logic [4*NIBBLES-1:0] op_b,
   input  logic                 cin,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_cin,
   input  logic [3:0]           add_sum,
   input  logic                 add_cout,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] result,
   output logic                 cout,
   output logic                 ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   acc_q;
   logic [W-1:0]   acc_upd;
   logic [W-1:0]   result_q;
   logic [IW-1:0]  idx_q;
   logic           carry_q;
   logic           cout_q;
   logic           done_q;
   logic           last;
   logic           ovf_calc;

   assign last = (idx_q == IW'(NIBBLES - 1));

   // Accumulator is cleared on start, so OR-ing the new nibble in place
   // is enough to build the sum.
   assign acc_upd = acc_q | (W'(add_sum) << {idx_q, 2'b00});

   // Signed overflow: operand sign bits agree, sum sign bit differs.
   assign ovf_calc = (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      add_a     = 4'h0;
      add_b     = 4'h0;
      add_cin   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = RUN;
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = 4'(a_q >> {idx_q, 2'b00});
            add_b   = 4'(b_q >> {idx_q, 2'b00});
            add_cin = carry_q;
            if (last)
               state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= op_a;
                  b_q     <= op_b;
                  carry_q <= cin;
                  idx_q   <= '0;
                  acc_q   <= '0;
               end
            end
            RUN: begin
               acc_q   <= acc_upd;
               carry_q <= add_cout;
               idx_q   <= idx_q + 1'b1;
               if (last) begin
                  result_q <= acc_upd;
                  cout_q   <= add_cout;
               end
            end
            DONE: begin
               done_q <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

`ifdef OVERFLOW_FLAG_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (state == RUN && last)
         ovf_q <= ovf_calc;
   end

   assign ovf = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_calc;
   assign ovf        = 1'b0;
`endif

   assign done   = done_q;
   assign result = result_q;
   assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed vectors with a scoreboard queue;
// a monitor pops expected sums whenever done is seen.

module tb_nibble_serial_adder_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

`ifdef OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic [3:0]   add_a;
   logic [3:0]   add_b;
   logic         add_cin;
   logic [3:0]   add_sum;
   logic         add_cout;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
      .cin      (cin),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .ovf      (ovf)
   );

   // External 4-bit adder
   assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         o;
      int           at;
   } exp_t;

   exp_t sbq[$];
   logic cin_log[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy === 1'b1)
            cin_log.push_back(add_cin);
         if (done === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("result", 32'(result), 32'(e.r));
               chk("cout", 32'(cout), 32'(e.c));
               chk("ovf", 32'(ovf), 32'(e.o));
               chk("done_cycle", 32'(cyc), 32'(e.at));
            end
         end
      end
   endtask

   // Called #1 after a rising edge with the DUT in IDLE; returns #1 after
   // the edge that raises done, so calls can run back-to-back.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] r,
                        input logic co, input logic o,
                        input bit glitch);
      exp_t e;
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      e.r   = r;
      e.c   = co;
      e.o   = o & OVF_EN;
      e.at  = cyc + N + 2;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a  = W'($urandom);
      op_b  = W'($urandom);
      cin   = 1'b1;
      for (int i = 0; i < N + 1; i++) begin
         if (glitch && (i == 1 || i == N)) begin
            start = 1'b1;
            op_a  = 16'hFFFF;
            op_b  = 16'hFFFF;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_result"}, 32'(result), 32'd0);
      chk({tag, "_cout"}, 32'(cout), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
      chk({tag, "_add_a"}, 32'(add_a), 32'd0);
      chk({tag, "_add_b"}, 32'(add_b), 32'd0);
      chk({tag, "_add_cin"}, 32'(add_cin), 32'd0);
   endtask

   initial begin
      logic [3:0] cins;
      fork
         monitor();
      join_none

      rst   = 1'b1;
      start = 1'b1;
      op_a  = 16'h1111;
      op_b  = 16'h2222;
      cin   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;

      do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

      cin_log.delete();
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk("cin_log_len", 32'(cin_log.size()), 32'd4);
      cins = 4'h0;
      for (int i = 0; i < 4 && i < cin_log.size(); i++)
         cins[3-i] = cin_log[i];
      chk("add_cin_seq", 32'(cins), 32'(4'b0111));

      do_op(16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      do_op(16'h0A0A, 16'h0505, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1);

      // Abort: reset lands in the second RUN cycle
      op_a  = 16'h1111;
      op_b  = 16'h2222;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("abort_busy_run", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_zero("abort");
      repeat (N + 3) @(posedge clk);
      #1;
      chk("abort_result", 32'(result), 32'd0);

      do_op(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
